sram_port_ctrl: RTL and testbench
=================================

Name: sram_port_ctrl

Overview:
- Two-requester controller for one asynchronous sram128x8$ macro.
- Pins the macro sees: active-low CE/OE/WR, 7-bit address, 8-bit bidirectional data.
- Round-robin arbitration between two clocked requesters, e.g. the fetch side and the memory-stage side.
- Converts each accepted request into a fixed setup/pulse/hold strobe sequence, drives write data with a tristate enable and returns registered read data.

Parameters:
- ADDR_W, 7: SRAM address width.
- DATA_W, 8: SRAM data width.
- T_SETUP, 1: cycles the address, data and CE are valid before the strobe asserts (>=1).
- T_PULSE, 2: cycles WR_n or OE_n is held low (>=1).
- T_HOLD, 1: cycles after the strobe deasserts while the address, data and CE are held (>=1).

Ports:
- clk  in  1  Single clock. All state changes on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- req0_valid  in  1  Requester 0 has a request.
- req0_wr  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_W  Request address.
- req0_wdata  in  DATA_W  Write data.
- req0_ready  out  1  Request 0 accepted this cycle.
- req1_valid, req1_wr, req1_addr, req1_wdata, req1_ready: same as requester 0.
- rsp_valid  out  1  One-cycle completion pulse.
- rsp_id  out  1  Requester that owns the completion.
- rsp_wr  out  1  The completed operation was a write.
- rsp_rdata  out  DATA_W  Read data, valid with rsp_valid when rsp_wr=0.
- sram_a  out  ADDR_W  SRAM address.
- sram_dout  out  DATA_W  Data to the SRAM DIO tristate driver.
- sram_dout_en  out  1  1 = drive DIO.
- sram_din  in  DATA_W  DIO as observed.
- sram_ce_n  out  1  Chip enable, active low.
- sram_oe_n  out  1  Output enable, active low.
- sram_wr_n  out  1  Write strobe, active low.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values: all sram_*_n = 1, sram_dout_en = 0, sram_a = 0, sram_dout = 0, rsp_valid = 0, rsp_id = 0, rsp_wr = 0, rsp_rdata = 0, busy = 0, FSM = IDLE, last_grant = 1.
- Reset asserted mid-transaction: the next cycle shows the full reset state, and no rsp_valid is emitted for the aborted operation.
- All sram_* outputs and all rsp_* outputs come straight from flops, so strobes are glitch-free.
- FSM states: IDLE -> SETUP -> PULSE -> HOLD -> IDLE. One down-counter is loaded with T_SETUP, T_PULSE or T_HOLD on entry to each state and decremented each cycle; the state advances when the count reaches 1.
- Arbitration:
  - Evaluated only in IDLE; readyX is combinational.
  - If only one valid is high, that requester gets ready.
  - If both are high, the requester other than last_grant wins.
  - At most one ready per cycle.
  - On accept (valid & ready): capture addr, wdata, wr and id; set last_grant = id; go to SETUP.
  - No ready outside IDLE.
- Write sequence:
  - SETUP: ce_n = 0, sram_a and sram_dout valid, dout_en = 1, wr_n = 1, oe_n = 1.
  - PULSE: wr_n = 0.
  - HOLD: wr_n = 1; ce_n, a, dout and dout_en held.
  - oe_n stays 1 throughout.
- Read sequence:
  - SETUP: ce_n = 0, oe_n = 0, dout_en = 0.
  - PULSE: oe_n = 0. sram_din is sampled on the edge that ends the last PULSE cycle.
  - HOLD: oe_n = 1, ce_n = 0.
  - wr_n stays 1 throughout.
- Latency: accept in cycle c. SETUP spans c+1 .. c+T_SETUP, then PULSE, then HOLD. rsp_valid is high for exactly cycle c+1+T_SETUP+T_PULSE+T_HOLD (c+5 with defaults), and the FSM is in IDLE in that same cycle. A new request can be accepted in that cycle.
- Bus turnaround:
  - dout_en is never 1 in any cycle where oe_n = 0.
  - Between a read and the next write there is at least one cycle with oe_n = 1 and dout_en = 0 (the HOLD/IDLE cycle).
- Idle state: ce_n = 1, sram_a and sram_dout keep their last values, and dout_en = 0.
- rsp_rdata keeps its value after a write response; it is updated only by reads.
- A request whose valid drops while not ready is simply not accepted; there is no error.

Test Plan:
1. Reset held 3 cycles, with both valids high during reset -> no ready; ce_n = oe_n = wr_n = 1, dout_en = 0, rsp_valid = 0, busy = 0.
2. req0 write addr 7F data 00, accepted at c, default params -> ce_n low c+1..c+4, wr_n low c+2..c+3, dout_en high c+1..c+4 with sram_dout = 00; rsp_valid at c+5 with rsp_id = 0, rsp_wr = 1.
3. req1 writes 7E <- FF, then req1 reads 7E via the SRAM model -> oe_n low during read-cycle offsets +1..+3, dout_en = 0 while oe_n = 0; rsp_rdata = FF with rsp_valid, rsp_wr = 0, rsp_id = 1.
4. Both valids held high after reset -> grants alternate 0,1,0,1 with accepts exactly 5 cycles apart; back-to-back accept coincides with each rsp_valid.
5. Reset pulsed during the second PULSE cycle of a write -> next cycle all strobes high, dout_en = 0, no rsp_valid ever issued for that write, and req0 wins the first arbitration afterwards.
6. Params T_SETUP=2, T_PULSE=4, T_HOLD=2 on a write -> wr_n low exactly 4 cycles starting c+3; rsp_valid at c+9.

Source files
------------

// File: rtl/sram_port_ctrl.sv
// Two-requester round-robin controller for one asynchronous sram128x8$ macro.
// Each accepted request becomes a registered setup/pulse/hold strobe sequence.
module sram_port_ctrl #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int T_SETUP = 1,
    parameter int T_PULSE = 2,
    parameter int T_HOLD  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_wr,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_wr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic              rsp_wr,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_dout_en,
    input  logic [DATA_W-1:0] sram_din,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_wr_n,
    output logic              busy
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              last_grant_r, last_grant_s;
    logic              op_wr_r, op_wr_s;
    logic              op_id_r, op_id_s;
    logic [DATA_W-1:0] rdata_cap_r, rdata_cap_s;
    logic              sel1_s, any_s;

    logic [ADDR_W-1:0] sram_a_s;
    logic [DATA_W-1:0] sram_dout_s;
    logic              sram_dout_en_s, sram_ce_n_s, sram_oe_n_s, sram_wr_n_s;
    logic              rsp_valid_s, rsp_id_s, rsp_wr_s;
    logic [DATA_W-1:0] rsp_rdata_s;

    assign busy = (state_r != IDLE);

    // Next-state, arbitration and next registered pin values.
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        last_grant_s   = last_grant_r;
        op_wr_s        = op_wr_r;
        op_id_s        = op_id_r;
        rdata_cap_s    = rdata_cap_r;
        sel1_s         = 1'b0;
        any_s          = 1'b0;
        req0_ready     = 1'b0;
        req1_ready     = 1'b0;
        sram_a_s       = sram_a;
        sram_dout_s    = sram_dout;
        sram_dout_en_s = sram_dout_en;
        sram_ce_n_s    = sram_ce_n;
        sram_oe_n_s    = sram_oe_n;
        sram_wr_n_s    = sram_wr_n;
        rsp_valid_s    = 1'b0;
        rsp_id_s       = rsp_id;
        rsp_wr_s       = rsp_wr;
        rsp_rdata_s    = rsp_rdata;

        case (state_r)
            IDLE: begin
                any_s  = req0_valid | req1_valid;
                // On contention the requester that did not win last time goes first.
                sel1_s = req1_valid & (~req0_valid | ~last_grant_r);
                if (any_s && !rst) begin
                    req0_ready     = ~sel1_s;
                    req1_ready     = sel1_s;
                    op_id_s        = sel1_s;
                    last_grant_s   = sel1_s;
                    op_wr_s        = sel1_s ? req1_wr : req0_wr;
                    sram_a_s       = sel1_s ? req1_addr : req0_addr;
                    sram_dout_s    = sel1_s ? req1_wdata : req0_wdata;
                    sram_dout_en_s = op_wr_s;
                    sram_oe_n_s    = op_wr_s;
                    sram_wr_n_s    = 1'b1;
                    sram_ce_n_s    = 1'b0;
                    state_s        = SETUP;
                    cnt_s          = CNT_W'(T_SETUP);
                end else begin
                    sram_ce_n_s    = 1'b1;
                    sram_dout_en_s = 1'b0;
                    sram_oe_n_s    = 1'b1;
                    sram_wr_n_s    = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_r == CNT_ONE) begin
                    state_s     = PULSE;
                    cnt_s       = CNT_W'(T_PULSE);
                    sram_wr_n_s = ~op_wr_r;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            PULSE: begin
                if (cnt_r == CNT_ONE) begin
                    state_s     = HOLD;
                    cnt_s       = CNT_W'(T_HOLD);
                    sram_wr_n_s = 1'b1;
                    sram_oe_n_s = 1'b1;
                    if (!op_wr_r) begin
                        rdata_cap_s = sram_din;
                    end else begin
                        rdata_cap_s = rdata_cap_r;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt_r == CNT_ONE) begin
                    state_s        = IDLE;
                    cnt_s          = {CNT_W{1'b0}};
                    sram_ce_n_s    = 1'b1;
                    sram_dout_en_s = 1'b0;
                    rsp_valid_s    = 1'b1;
                    rsp_id_s       = op_id_r;
                    rsp_wr_s       = op_wr_r;
                    if (!op_wr_r) begin
                        rsp_rdata_s = rdata_cap_r;
                    end else begin
                        rsp_rdata_s = rsp_rdata;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, capture and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            last_grant_r <= 1'b1;
            op_wr_r      <= 1'b0;
            op_id_r      <= 1'b0;
            rdata_cap_r  <= {DATA_W{1'b0}};
            sram_a       <= {ADDR_W{1'b0}};
            sram_dout    <= {DATA_W{1'b0}};
            sram_dout_en <= 1'b0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_wr_n    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_wr       <= 1'b0;
            rsp_rdata    <= {DATA_W{1'b0}};
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            last_grant_r <= last_grant_s;
            op_wr_r      <= op_wr_s;
            op_id_r      <= op_id_s;
            rdata_cap_r  <= rdata_cap_s;
            sram_a       <= sram_a_s;
            sram_dout    <= sram_dout_s;
            sram_dout_en <= sram_dout_en_s;
            sram_ce_n    <= sram_ce_n_s;
            sram_oe_n    <= sram_oe_n_s;
            sram_wr_n    <= sram_wr_n_s;
            rsp_valid    <= rsp_valid_s;
            rsp_id       <= rsp_id_s;
            rsp_wr       <= rsp_wr_s;
            rsp_rdata    <= rsp_rdata_s;
        end
    end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: transaction-level reference model checked every cycle,
// directed literal checks, randomized traffic and a second instance with long timing.
module tb_sram_port_ctrl;

    localparam int AW = 7;
    localparam int DW = 8;
    localparam int TS = 1;
    localparam int TP = 2;
    localparam int TH = 1;
    localparam int L  = TS + TP + TH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req0_valid, req0_wr, req0_ready;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_wr, req1_ready;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp_valid, rsp_id, rsp_wr;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_dout, sram_din;
    logic          sram_dout_en, sram_ce_n, sram_oe_n, sram_wr_n, busy;

    logic [DW-1:0] junk;
    logic [DW-1:0] sram_mem [128];

    // second instance with stretched timing
    logic          b_v0, b_wr0, b_ready0, b_v1, b_wr1, b_ready1;
    logic [AW-1:0] b_a0, b_a1, b_sram_a;
    logic [DW-1:0] b_d0, b_d1, b_rdata, b_sram_dout, b_sram_din;
    logic          b_rsp_valid, b_rsp_id, b_rsp_wr;
    logic          b_dout_en, b_ce_n, b_oe_n, b_wr_n, b_busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    sram_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata),
        .sram_a(sram_a), .sram_dout(sram_dout), .sram_dout_en(sram_dout_en),
        .sram_din(sram_din), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_wr_n(sram_wr_n), .busy(busy)
    );

    sram_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .T_SETUP(2), .T_PULSE(4), .T_HOLD(2)) u_dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(b_v0), .req0_wr(b_wr0), .req0_addr(b_a0),
        .req0_wdata(b_d0), .req0_ready(b_ready0),
        .req1_valid(b_v1), .req1_wr(b_wr1), .req1_addr(b_a1),
        .req1_wdata(b_d1), .req1_ready(b_ready1),
        .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id), .rsp_wr(b_rsp_wr), .rsp_rdata(b_rdata),
        .sram_a(b_sram_a), .sram_dout(b_sram_dout), .sram_dout_en(b_dout_en),
        .sram_din(b_sram_din), .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n),
        .sram_wr_n(b_wr_n), .busy(b_busy)
    );

    // Asynchronous SRAM: drives stored data only while selected and output-enabled.
    assign sram_din = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_a] : junk;

    initial begin
        for (int i = 0; i < 128; i++) sram_mem[i] <= DW'($urandom);
        forever begin
            @(posedge clk);
            if (!sram_ce_n && !sram_wr_n && sram_dout_en) sram_mem[sram_a] <= sram_dout;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference model: one transaction at a time, phase known from its cycle offset.
    initial begin
        logic          m_active = 1'b0;
        int            m_k = 0;
        logic          m_id = 1'b0, m_wr = 1'b0, m_last_grant = 1'b1;
        logic [AW-1:0] m_addr = '0, m_last_a = '0;
        logic [DW-1:0] m_wdata = '0;
        logic          m_rsp_valid = 1'b0, m_rsp_id = 1'b0, m_rsp_wr = 1'b0;
        logic [DW-1:0] m_rsp_rdata = '0;
        logic          e_ce, e_oe, e_wr, e_den, e_busy, e_r0, e_r1;
        int            winner;
        @(posedge clk);
        forever begin
            @(negedge clk);
            e_ce = 1'b1; e_oe = 1'b1; e_wr = 1'b1; e_den = 1'b0; e_busy = 1'b0;
            e_r0 = 1'b0; e_r1 = 1'b0; winner = -1;
            if (m_active) begin
                e_ce = 1'b0; e_busy = 1'b1; e_den = m_wr;
                if (m_wr && m_k > TS && m_k <= TS + TP) e_wr = 1'b0;
                if (!m_wr && m_k <= TS + TP) e_oe = 1'b0;
            end else if (!rst) begin
                if (req0_valid && req1_valid) winner = m_last_grant ? 0 : 1;
                else if (req0_valid) winner = 0;
                else if (req1_valid) winner = 1;
                e_r0 = (winner == 0);
                e_r1 = (winner == 1);
            end
            chk("m_ready0", req0_ready, e_r0);
            chk("m_ready1", req1_ready, e_r1);
            chk("m_ce_n", sram_ce_n, e_ce);
            chk("m_oe_n", sram_oe_n, e_oe);
            chk("m_wr_n", sram_wr_n, e_wr);
            chk("m_dout_en", sram_dout_en, e_den);
            chk("m_busy", busy, e_busy);
            chk("m_addr", sram_a, m_active ? m_addr : m_last_a);
            if (e_den) chk("m_dout", sram_dout, m_wdata);
            chk("m_turnaround", sram_dout_en & ~sram_oe_n, 1'b0);
            chk("m_rsp_valid", rsp_valid, m_rsp_valid);
            chk("m_rsp_id", rsp_id, m_rsp_id);
            chk("m_rsp_wr", rsp_wr, m_rsp_wr);
            chk("m_rsp_rdata", rsp_rdata, m_rsp_rdata);
            if (rst) begin
                m_active = 1'b0; m_last_grant = 1'b1; m_last_a = '0;
                m_rsp_valid = 1'b0; m_rsp_id = 1'b0; m_rsp_wr = 1'b0; m_rsp_rdata = '0;
            end else begin
                m_rsp_valid = 1'b0;
                if (m_active) begin
                    if (m_k == L) begin
                        m_rsp_valid = 1'b1; m_rsp_id = m_id; m_rsp_wr = m_wr;
                        if (!m_wr) m_rsp_rdata = sram_mem[m_addr];
                        m_active = 1'b0;
                    end else begin
                        m_k++;
                    end
                end else if (winner >= 0) begin
                    m_active = 1'b1; m_k = 1;
                    m_id   = (winner == 1);
                    m_wr   = (winner == 1) ? req1_wr : req0_wr;
                    m_addr = (winner == 1) ? req1_addr : req0_addr;
                    m_wdata = (winner == 1) ? req1_wdata : req0_wdata;
                    m_last_grant = m_id; m_last_a = m_addr;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        junk = DW'($urandom);
    endtask

    task automatic txn(input logic id, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input logic [DW-1:0] exp_rd);
        step();
        if (id) begin
            req1_valid = 1'b1; req1_wr = wr; req1_addr = addr; req1_wdata = data; req0_valid = 1'b0;
        end else begin
            req0_valid = 1'b1; req0_wr = wr; req0_addr = addr; req0_wdata = data; req1_valid = 1'b0;
        end
        @(negedge clk);
        chk("txn_accept", id ? req1_ready : req0_ready, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            @(negedge clk);
            chk("txn_ce_n", sram_ce_n, (k <= 4) ? 1'b0 : 1'b1);
            chk("txn_wr_n", sram_wr_n, (wr && (k == 2 || k == 3)) ? 1'b0 : 1'b1);
            chk("txn_oe_n", sram_oe_n, (!wr && k <= 3) ? 1'b0 : 1'b1);
            chk("txn_dout_en", sram_dout_en, (wr && k <= 4) ? 1'b1 : 1'b0);
            chk("txn_rsp_valid", rsp_valid, (k == 5) ? 1'b1 : 1'b0);
            if (wr && k <= 4) chk("txn_dout", sram_dout, data);
            if (k == 5) begin
                chk("txn_rsp_id", rsp_id, id);
                chk("txn_rsp_wr", rsp_wr, wr);
                if (!wr) chk("txn_rdata", rsp_rdata, exp_rd);
            end
        end
    endtask

    task automatic rand_reqs();
        req0_wr = 1'($urandom); req0_addr = AW'($urandom_range(0, 7)); req0_wdata = DW'($urandom);
        req1_wr = 1'($urandom); req1_addr = AW'($urandom_range(0, 7)); req1_wdata = DW'($urandom);
    endtask

    initial begin
        int last_c = 0;
        int nacc = 0;
        rst = 1'b1; junk = '0;
        req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b1; req1_wr = 1'b0; req1_addr = '0; req1_wdata = '0;
        b_v0 = 1'b0; b_wr0 = 1'b0; b_a0 = '0; b_d0 = '0;
        b_v1 = 1'b0; b_wr1 = 1'b0; b_a1 = '0; b_d1 = '0; b_sram_din = '0;

        // reset with both requesters pending
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("rst_ready0", req0_ready, 1'b0);
            chk("rst_ready1", req1_ready, 1'b0);
        end
        chk("rst_ce_n", sram_ce_n, 1'b1);
        chk("rst_oe_n", sram_oe_n, 1'b1);
        chk("rst_wr_n", sram_wr_n, 1'b1);
        chk("rst_dout_en", sram_dout_en, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        step();
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

        txn(1'b0, 1'b1, 7'h7F, 8'h00, 8'h00);
        txn(1'b1, 1'b1, 7'h7E, 8'hFF, 8'h00);
        txn(1'b1, 1'b0, 7'h7E, 8'h00, 8'hFF);

        // contention: grants alternate 0,1,0,1 back to back
        step();
        req0_valid = 1'b1; req1_valid = 1'b1; rand_reqs();
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                chk("alt_grant", req1_ready, nacc % 2);
                chk("alt_one_ready", req0_ready & req1_ready, 1'b0);
                if (nacc > 0) begin
                    chk("alt_gap", cyc - last_c, 5);
                    chk("alt_rsp_with_accept", rsp_valid, 1'b1);
                end
                last_c = cyc;
                nacc++;
            end
            step();
            rand_reqs();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("alt_count", nacc, 5);
        repeat (6) step();

        // reset in the second PULSE cycle of a write
        req0_valid = 1'b1; req0_wr = 1'b1; req0_addr = 7'h33; req0_wdata = 8'h5A;
        @(negedge clk);
        chk("abort_accept", req0_ready, 1'b1);
        step(); req0_valid = 1'b0;
        step();
        step(); rst = 1'b1;
        @(negedge clk);
        chk("abort_in_pulse", sram_wr_n, 1'b0);
        step(); rst = 1'b0;
        @(negedge clk);
        chk("abort_ce_n", sram_ce_n, 1'b1);
        chk("abort_wr_n", sram_wr_n, 1'b1);
        chk("abort_oe_n", sram_oe_n, 1'b1);
        chk("abort_dout_en", sram_dout_en, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_addr", sram_a, 7'h00);
        for (int i = 0; i < 6; i++) begin
            chk("abort_no_rsp", rsp_valid, 1'b0);
            step();
            @(negedge clk);
        end
        step();
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("abort_first_grant0", req0_ready, 1'b1);
        chk("abort_first_grant1", req1_ready, 1'b0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (6) step();

        // randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            step();
            rst = ($urandom_range(0, 299) == 0);
            req0_valid = ($urandom_range(0, 1) == 1);
            req1_valid = ($urandom_range(0, 2) != 0);
            rand_reqs();
        end
        step();
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

        // stretched timing instance: setup 2, pulse 4, hold 2
        step();
        b_v0 = 1'b1; b_wr0 = 1'b1; b_a0 = 7'h05; b_d0 = 8'hA5;
        @(negedge clk);
        chk("b_accept", b_ready0, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 1) b_v0 = 1'b0;
            @(negedge clk);
            chk("b_wr_n", b_wr_n, (k >= 3 && k <= 6) ? 1'b0 : 1'b1);
            chk("b_ce_n", b_ce_n, (k <= 8) ? 1'b0 : 1'b1);
            chk("b_oe_n", b_oe_n, 1'b1);
            chk("b_rsp_valid", b_rsp_valid, (k == 9) ? 1'b1 : 1'b0);
            chk("b_busy", b_busy, (k <= 8) ? 1'b1 : 1'b0);
            if (k <= 8) begin
                chk("b_dout_en", b_dout_en, 1'b1);
                chk("b_addr", b_sram_a, 7'h05);
                chk("b_dout", b_sram_dout, 8'hA5);
            end
            if (k == 9) begin
                chk("b_rsp_id", b_rsp_id, 1'b0);
                chk("b_rsp_wr", b_rsp_wr, 1'b1);
                chk("b_rdata_kept", b_rdata, 8'h00);
                chk("b_ready1", b_ready1, 1'b0);
            end
        end

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
